morph_window: RTL and testbench
===============================

Name: morph_window

Overview:
- Streaming 3x3 binary morphology stage between the 1-bit image ROM output and the display output mux.
- Consumes the raster-ordered 256x128 binary image one pixel per accepted beat.
- Holds two line buffers and a 3x3 window.
- Emits one processed pixel per input pixel, in the same raster order, with fixed latency and an end-of-frame drain.

Parameters:
- IMG_W, 256, image width in pixels (power of two, 4..1024).
- IMG_H, 128, image height in lines (power of two, 4..1024).

Ports:
- clock  input  1  pixel clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sof  input  1  start of frame; qualified by pixel_valid; marks raster pixel (0,0).
- pixel_valid  input  1  pixel_in is valid this cycle.
- pixel_in  input  1  binary source pixel.
- op  input  2  operation: 00 pass, 01 erode, 10 dilate, 11 gradient (dilate AND NOT erode).
- pixel_out  output  1  processed pixel.
- out_valid  output  1  pixel_out, out_row and out_col are valid this cycle.
- out_row  output  log2(IMG_H)  row of pixel_out.
- out_col  output  log2(IMG_W)  column of pixel_out.
- busy  output  1  frame in progress (FILL, RUN or DRAIN).
- frame_done  output  1  one-cycle pulse with the final output of a frame.

Behaviour:
- Reset value of every output and register is 0. FSM resets to IDLE. Line buffers are not cleared; their contents are masked by border logic.
- Input is accepted when pixel_valid=1 in state FILL or RUN, or when sof&pixel_valid=1 in any state.
- Input raster index k = row*IMG_W + col, with N = IMG_W*IMG_H and L = IMG_W+1.
- FSM:
  - IDLE: waits for sof&pixel_valid. On that beat: accept pixel 0, latch op into op_q, go to FILL.
  - FILL: accept inputs until k = L-1 is accepted, then go to RUN. No outputs in FILL.
  - RUN: the accept of input k = j+L produces output j, registered on the next cycle (out_valid=1, out_row/out_col = coordinates of j). After input N-1 is accepted, go to DRAIN.
  - DRAIN: emits outputs N-L .. N-1 on L consecutive clocks, ignoring pixel_valid. frame_done=1 with output N-1. Then go to IDLE.
- sof&pixel_valid in FILL, RUN or DRAIN aborts the current frame. No further outputs for it, no frame_done. That beat is taken as pixel 0 of the new frame and the FSM goes to FILL.
- Any other input arriving in DRAIN or IDLE is dropped.
- op is sampled only at sof. Changes to op mid-frame have no effect.
- Window for output (r,c) is the neighbours (r-1..r+1, c-1..c+1).
- Out-of-image neighbours (row <0 or >=IMG_H, column <0 or >=IMG_W) are neutral: treated as 1 for erode and 0 for dilate.
- Columns never wrap: column IMG_W-1 has no right neighbour and column 0 has no left neighbour.
- Functions:
  - erode = AND over the 9 neighbours.
  - dilate = OR over the 9 neighbours.
  - pass = centre pixel.
  - gradient = dilate & ~erode.
- pixel_valid gaps stall the pipeline in RUN. out_valid only follows an accepted beat; no output is produced without input.
- Asynchronous reset at any point returns to IDLE within the same cycle and clears out_valid, busy and frame_done.
- busy=1 in FILL, RUN and DRAIN.

Test Plan:
- Latency, op=00: random frame, continuous pixel_valid. Required: first out_valid one cycle after input 257 is accepted, with out_row=0, out_col=0. Exactly 32768 outputs equal to the input. frame_done coincides with out_row=127, out_col=255.
- Dilate, op=10: all-zero frame with a single 1 at (10,20). Required: ones exactly at rows 9..11 × columns 19..21, zeros elsewhere. Repeat with the 1 at (5,255). Required: ones only at columns 254..255 (no wrap into column 0).
- Erode, op=01: all-ones frame. Required: all 32768 outputs are 1 (border neutral). Then all-ones with a single 0 at (0,0). Required: zeros at (0,0), (0,1), (1,0), (1,1) only.
- Gradient, op=11: an 8x8 block of ones at rows 20..27, columns 40..47. Required: ones on rows 19..28 × columns 39..48, excluding rows 21..26 × columns 41..46.
- Stalls and op latch: pixel_valid toggling 1,0,0,1 randomly, and op changed from 10 to 01 mid-frame. Required: output identical to the continuous-valid dilate result.
- Abort and reset:
  - sof&pixel_valid at input 5000. Required: no frame_done for the aborted frame, and the new frame completes correctly.
  - reset low mid-DRAIN. Required: out_valid=0 and busy=0 immediately, state IDLE.

Source files
------------

// File: rtl/morph_window.sv
// Streaming 3x3 binary morphology (pass / erode / dilate / gradient) over a raster-ordered
// binary image, using two line buffers and a sliding window with neutral out-of-image borders.
module morph_window #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 128
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sof,
    input  logic                     pixel_valid,
    input  logic                     pixel_in,
    input  logic [1:0]               op,
    output logic                     pixel_out,
    output logic                     out_valid,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_DRAIN} state_t;
    typedef enum logic [1:0] {OP_PASS = 2'b00, OP_ERODE = 2'b01,
                              OP_DILATE = 2'b10, OP_GRAD = 2'b11} op_t;

    state_t state, state_nxt;
    op_t    op_q;

    // Coordinates of the next input pixel (line buffer column) and of the next output centre.
    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic [CW-1:0] ctr_col;
    logic [RW-1:0] ctr_row;

    logic line0 [IMG_W];
    logic line1 [IMG_W];

    // Window columns, bit 2 = top row, bit 1 = centre row, bit 0 = bottom row.
    logic [2:0] win_l, win_c, tap;

    logic          start, accept, step, emit;
    logic          ctr_last, fill_done, run_done;
    logic [CW-1:0] wr_col;
    logic [2:0]    row_ok;
    logic          col_l_ok, col_r_ok;
    logic          ero, dil, result;

    assign start     = sof & pixel_valid;
    assign accept    = start | (pixel_valid & (state == ST_FILL || state == ST_RUN));
    assign step      = accept | (state == ST_DRAIN);
    assign emit      = !start && ((state == ST_RUN && pixel_valid) || state == ST_DRAIN);
    assign ctr_last  = (ctr_row == ROW_LAST) && (ctr_col == COL_LAST);
    assign fill_done = (state == ST_FILL) && accept && !start
                       && (in_row == RW'(1)) && (in_col == '0);
    assign run_done  = (state == ST_RUN) && accept && !start
                       && (in_row == ROW_LAST) && (in_col == COL_LAST);
    assign busy      = (state != ST_IDLE);

    // A new frame always lands at column 0, even when it cuts an earlier frame short.
    assign wr_col = start ? '0 : in_col;
    assign tap    = {line1[wr_col], line0[wr_col], accept & pixel_in};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt = state;
        unique case (state)
            ST_IDLE:  state_nxt = ST_IDLE;
            ST_FILL:  if (fill_done) state_nxt = ST_RUN;
            ST_RUN:   if (run_done)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (ctr_last)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (start) state_nxt = ST_FILL;
    end

    // Out-of-image neighbours contribute 1 to the AND and 0 to the OR.
    always_comb begin
        row_ok   = {ctr_row != '0, 1'b1, ctr_row != ROW_LAST};
        col_l_ok = (ctr_col != '0);
        col_r_ok = (ctr_col != COL_LAST);
        ero = (&(win_l | ~row_ok) | ~col_l_ok) & (&(win_c | ~row_ok))
              & (&(tap | ~row_ok) | ~col_r_ok);
        dil = ((|(win_l & row_ok)) & col_l_ok) | (|(win_c & row_ok))
              | ((|(tap & row_ok)) & col_r_ok);
        result = win_c[1];
        unique case (op_q)
            OP_PASS:   result = win_c[1];
            OP_ERODE:  result = ero;
            OP_DILATE: result = dil;
            OP_GRAD:   result = dil & ~ero;
            default:   result = win_c[1];
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op_q       <= OP_PASS;
            in_col     <= '0;
            in_row     <= '0;
            ctr_col    <= '0;
            ctr_row    <= '0;
            win_l      <= '0;
            win_c      <= '0;
            pixel_out  <= 1'b0;
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) op_q <= op_t'(op);

            if (start) begin
                in_col <= CW'(1);
                in_row <= '0;
            end else if (step) begin
                in_col <= in_col + 1'b1;
                if (in_col == COL_LAST) in_row <= in_row + 1'b1;
            end

            if (step) begin
                win_l <= win_c;
                win_c <= tap;
            end

            if (start) begin
                ctr_col <= '0;
                ctr_row <= '0;
            end else if (emit) begin
                ctr_col <= ctr_col + 1'b1;
                if (ctr_col == COL_LAST) ctr_row <= ctr_row + 1'b1;
            end

            out_valid  <= emit;
            frame_done <= emit && (state == ST_DRAIN) && ctr_last;
            if (emit) begin
                pixel_out <= result;
                out_row   <= ctr_row;
                out_col   <= ctr_col;
            end
        end
    end

    // NOTE: line buffers carry no reset; stale contents only reach border positions,
    // which the neighbour masks above neutralise.
    always_ff @(posedge clock) begin
        if (step) begin
            line1[wr_col] <= line0[wr_col];
            line0[wr_col] <= tap[0];
        end
    end

endmodule

// File: tb/tb_morph_window.sv
// Directed bench for morph_window on a 64x32 image; captured output frames are compared
// against hand-derived patterns for each operation.
module tb_morph_window;

    localparam int W = 64;
    localparam int H = 32;
    localparam int N = W * H;
    localparam int L = W + 1;

    localparam int M_PASS = 0, M_DOT = 1, M_EDGE = 2, M_ONES = 3, M_CORNER = 4, M_GRAD = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sof = 1'b0;
    logic       pixel_valid = 1'b0;
    logic       pixel_in = 1'b0;
    logic [1:0] op = 2'b00;
    logic       pixel_out, out_valid, busy, frame_done;
    logic [4:0] out_row;
    logic [5:0] out_col;

    always #5 clock = ~clock;

    morph_window #(.IMG_W(W), .IMG_H(H)) dut (
        .clock(clock), .reset(reset), .sof(sof), .pixel_valid(pixel_valid),
        .pixel_in(pixel_in), .op(op), .pixel_out(pixel_out), .out_valid(out_valid),
        .out_row(out_row), .out_col(out_col), .busy(busy), .frame_done(frame_done)
    );

    int   n_cmp = 0, n_err = 0;
    logic img [H][W];
    logic cap [H][W];
    int   n_out = 0, order_err = 0, fd_cnt = 0, fd_idx = -2;
    int   first_out_cyc = -1, acc_cyc_l = -3, cyc = 0, mon_idx;
    int   prev_n_out = 0, prev_fd = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (reset) begin
            if (out_valid) begin
                mon_idx = int'(out_row) * W + int'(out_col);
                if (mon_idx != n_out) order_err++;
                if (n_out == 0) first_out_cyc = cyc;
                cap[out_row][out_col] = pixel_out;
                n_out++;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_idx = out_valid ? int'(out_row) * W + int'(out_col) : -1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_img(input logic v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = v;
    endtask

    task automatic random_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 1'($urandom_range(0, 1));
    endtask

    // Drives one frame from img; stop_at >= 0 ends the frame early (before that index).
    task automatic send_frame(input logic [1:0] op_v, input bit gaps, input int op_flip_at,
                              input int stop_at, input bit drain_junk);
        for (int k = 0; k < N; k++) begin
            if (k == stop_at) return;
            if (gaps && k > 0) begin
                int ng;
                ng = $urandom_range(0, 2);
                for (int g = 0; g < ng; g++) begin
                    sof = 1'b0;
                    pixel_valid = 1'b0;
                    pixel_in = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            sof = (k == 0);
            pixel_valid = 1'b1;
            pixel_in = img[k / W][k % W];
            if (k == 0) op = op_v;
            if (op_flip_at >= 0 && k == op_flip_at) op = 2'b01;
            if (k == L) acc_cyc_l = cyc + 1;
            tick();
            if (k == 0) begin
                prev_n_out = n_out;
                prev_fd = fd_cnt;
                n_out = 0;
                order_err = 0;
                fd_cnt = 0;
                fd_idx = -2;
                first_out_cyc = -1;
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++)
                        cap[r][c] = 1'bx;
            end
        end
        sof = 1'b0;
        pixel_valid = drain_junk;
        pixel_in = 1'b1;
    endtask

    task automatic wait_frame();
        for (int i = 0; i < L + 20 && n_out < N; i++) tick();
        tick();
        pixel_valid = 1'b0;
    endtask

    function automatic logic expv(input int mode, input int r, input int c);
        case (mode)
            M_PASS:   return img[r][c];
            M_DOT:    return (r >= 9 && r <= 11 && c >= 19 && c <= 21);
            M_EDGE:   return (r >= 4 && r <= 6 && c >= W - 2);
            M_ONES:   return 1'b1;
            M_CORNER: return !(r <= 1 && c <= 1);
            M_GRAD:   return (r >= 19 && r <= 28 && c >= 39 && c <= 48)
                             && !(r >= 21 && r <= 26 && c >= 41 && c <= 46);
            default:  return 1'bx;
        endcase
    endfunction

    task automatic check_frame(input string tag, input int mode);
        int bad;
        bad = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (cap[r][c] !== expv(mode, r, c)) begin
                    if (bad == 0) $display("%s: first differing pixel at row %0d col %0d", tag, r, c);
                    bad++;
                end
        check({tag, "_bad_pixels"}, bad, 0);
        check({tag, "_out_count"}, n_out, N);
        check({tag, "_out_order"}, order_err, 0);
        check({tag, "_frame_done_count"}, fd_cnt, 1);
        check({tag, "_frame_done_index"}, fd_idx, N - 1);
        check({tag, "_idle_after"}, busy, 0);
    endtask

    initial begin
        tick();
        tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_coords", {out_row, out_col, pixel_out}, 0);
        reset = 1'b1;
        tick();

        // sof without pixel_valid and plain valid beats in IDLE are both ignored
        sof = 1'b1;
        tick();
        check("sof_needs_valid", busy, 0);
        sof = 1'b0;
        pixel_valid = 1'b1;
        repeat (3) tick();
        check("idle_drops_busy", busy, 0);
        check("idle_drops_out", out_valid, 0);
        pixel_valid = 1'b0;

        // pass-through with latency check; junk valid beats during drain must be ignored
        random_img();
        send_frame(2'b00, 1'b0, -1, -1, 1'b1);
        check("busy_in_drain", busy, 1);
        wait_frame();
        check("first_out_latency", first_out_cyc, acc_cyc_l);
        check_frame("pass", M_PASS);

        fill_img(1'b0);
        img[10][20] = 1'b1;
        send_frame(2'b10, 1'b0, -1, -1, 1'b0);
        wait_frame();
        check_frame("dilate_dot", M_DOT);

        fill_img(1'b0);
        img[5][W - 1] = 1'b1;
        send_frame(2'b10, 1'b0, -1, -1, 1'b0);
        wait_frame();
        check_frame("dilate_edge", M_EDGE);

        fill_img(1'b1);
        send_frame(2'b01, 1'b0, -1, -1, 1'b0);
        wait_frame();
        check_frame("erode_ones", M_ONES);

        img[0][0] = 1'b0;
        send_frame(2'b01, 1'b0, -1, -1, 1'b0);
        wait_frame();
        check_frame("erode_corner", M_CORNER);

        fill_img(1'b0);
        for (int r = 20; r <= 27; r++)
            for (int c = 40; c <= 47; c++)
                img[r][c] = 1'b1;
        send_frame(2'b11, 1'b0, -1, -1, 1'b0);
        wait_frame();
        check_frame("gradient", M_GRAD);

        // random valid gaps, op switched to erode mid-frame
        fill_img(1'b0);
        img[10][20] = 1'b1;
        send_frame(2'b10, 1'b1, 500, -1, 1'b0);
        wait_frame();
        check_frame("stall_oplatch", M_DOT);

        // abort at input 1000, then a complete dilate frame
        random_img();
        send_frame(2'b00, 1'b0, -1, 1000, 1'b0);
        fill_img(1'b0);
        img[10][20] = 1'b1;
        send_frame(2'b10, 1'b0, -1, -1, 1'b0);
        check("abort_out_count", prev_n_out, 1000 - L);
        check("abort_no_frame_done", prev_fd, 0);
        wait_frame();
        check_frame("after_abort", M_DOT);

        // asynchronous reset in the middle of DRAIN
        send_frame(2'b10, 1'b0, -1, -1, 1'b0);
        repeat (10) tick();
        check("drain_busy_before_rst", busy, 1);
        check("drain_valid_before_rst", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_drain_out_valid", out_valid, 0);
        check("rst_drain_busy", busy, 0);
        check("rst_drain_frame_done", frame_done, 0);
        tick();
        #2 reset = 1'b1;
        pixel_valid = 1'b1;
        repeat (4) tick();
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_no_done", fd_cnt, 0);
        pixel_valid = 1'b0;

        send_frame(2'b10, 1'b0, -1, -1, 1'b0);
        wait_frame();
        check_frame("post_reset", M_DOT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
